// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_unit
//  Description : Executes decoded load/store/lui operations against a
//                word-wide data memory over a req/ack handshake. Performs
//                byte-lane steering, sign/zero extension and lui bypass.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  load_select,
    input  logic [1:0]  store_signal,
    input  logic        zero_or_sign,
    input  logic        lui_or_other,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [15:0] imm,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Counter is 8 bits wide; the limit is taken modulo that width.
    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    logic [1:0]  state_q, state_d;
    logic        busy_q, busy_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic        sext_q, sext_d;
    logic [31:0] rdata_q, rdata_d;
    logic        merr_q, merr_d;
    logic        terr_q, terr_d;

    logic [1:0]  w_req_size;
    logic        w_misaligned;
    logic [3:0]  w_req_be;
    logic [31:0] w_req_wdata;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_ext;

    // Decode access size, alignment and store lane steering from the live inputs
    always_comb begin : p_decode
        w_req_size  = SZ_WORD;
        w_req_be    = 4'b1111;
        w_req_wdata = wdata;
        if (mem_write) begin
            case (store_signal)
                2'b00:   w_req_size = SZ_BYTE;
                2'b01:   w_req_size = SZ_HALF;
                default: w_req_size = SZ_WORD;
            endcase
        end else begin
            case (load_select)
                2'b01:   w_req_size = SZ_BYTE;
                2'b10:   w_req_size = SZ_HALF;
                default: w_req_size = SZ_WORD;
            endcase
        end
        w_misaligned = ((w_req_size == SZ_HALF) && addr[0]) ||
                       ((w_req_size == SZ_WORD) && (addr[1:0] != 2'b00));
        // Loads always fetch the whole word; only stores narrow the lanes.
        if (mem_write) begin
            case (w_req_size)
                SZ_BYTE: begin
                    w_req_be    = 4'b0001 << addr[1:0];
                    w_req_wdata = {4{wdata[7:0]}};
                end
                SZ_HALF: begin
                    w_req_be    = addr[1] ? 4'b1100 : 4'b0011;
                    w_req_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    w_req_be    = 4'b1111;
                    w_req_wdata = wdata;
                end
            endcase
        end
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin : p_extract
        case (lane_q)
            2'd0:    w_lane_byte = dmem_rdata[7:0];
            2'd1:    w_lane_byte = dmem_rdata[15:8];
            2'd2:    w_lane_byte = dmem_rdata[23:16];
            default: w_lane_byte = dmem_rdata[31:24];
        endcase
        w_lane_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            SZ_BYTE: w_load_ext = {{24{sext_q & w_lane_byte[7]}}, w_lane_byte};
            SZ_HALF: w_load_ext = {{16{sext_q & w_lane_half[15]}}, w_lane_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in REQ, pulse in RESP
    always_comb begin : p_next
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        lane_d  = lane_q;
        sext_d  = sext_q;
        rdata_d = rdata_q;
        merr_d  = merr_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (lui_or_other) begin
                        rdata_d = {imm, 16'h0000};
                        merr_d  = 1'b0;
                        terr_d  = 1'b0;
                        state_d = S_RESP;
                    end else if (mem_write || mem_read) begin
                        merr_d = w_misaligned;
                        terr_d = 1'b0;
                        if (w_misaligned) begin
                            state_d = S_RESP;
                        end else begin
                            state_d = S_REQ;
                            busy_d  = 1'b1;
                            cnt_d   = 8'd0;
                            we_d    = mem_write;
                            be_d    = w_req_be;
                            waddr_d = addr[31:2];
                            wdata_d = w_req_wdata;
                            size_d  = w_req_size;
                            lane_d  = addr[1:0];
                            sext_d  = zero_or_sign;
                        end
                    end
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    if (!we_q) begin
                        rdata_d = w_load_ext;
                    end
                    state_d = S_RESP;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else if ((cnt_q + 8'd1) == TIMEOUT_CNT) begin
                    terr_d  = 1'b1;
                    state_d = S_RESP;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and request registers with synchronous active-low reset
    always_ff @(posedge clk) begin : p_regs
        if (!reset_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            waddr_q <= 30'd0;
            wdata_q <= 32'd0;
            size_q  <= SZ_BYTE;
            lane_q  <= 2'd0;
            sext_q  <= 1'b0;
            rdata_q <= 32'd0;
            merr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            sext_q  <= sext_d;
            rdata_q <= rdata_d;
            merr_q  <= merr_d;
            terr_q  <= terr_d;
        end
    end

    // Memory-side outputs are quiet whenever no request is outstanding
    assign dmem_req     = (state_q == S_REQ);
    assign dmem_we      = dmem_req & we_q;
    assign dmem_be      = dmem_req ? be_q : 4'b0000;
    assign dmem_addr    = dmem_req ? {waddr_q, 2'b00} : 32'd0;
    assign dmem_wdata   = dmem_req ? wdata_q : 32'd0;

    assign busy         = busy_q;
    assign done         = (state_q == S_RESP);
    assign rdata        = rdata_q;
    assign misalign_err = merr_q;
    assign timeout_err  = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_access_unit
//  Description : Directed self-checking bench for dmem_access_unit with a
//                queue of expected completions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_access_unit;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  load_select;
    logic [1:0]  store_signal;
    logic        zero_or_sign;
    logic        lui_or_other;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] imm;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign_err;
    logic        timeout_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    dmem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .load_select  (load_select),
        .store_signal (store_signal),
        .zero_or_sign (zero_or_sign),
        .lui_or_other (lui_or_other),
        .addr         (addr),
        .wdata        (wdata),
        .imm          (imm),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_be      (dmem_be),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          done_cyc;
        int          req_cnt;
        logic [31:0] rdata;
        logic        merr;
        logic        terr;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-lane load reference: shift the word down and mask
    function automatic logic [31:0] model_lb(input logic [31:0] w, input int lane, input logic sx);
        logic [31:0] b;
        b = (w >> (8 * lane)) & 32'h0000_00FF;
        if (sx && b[7]) b = b | 32'hFFFF_FF00;
        return b;
    endfunction

    // One access: drive, respond to dmem_req, then pop the queued expectation at done
    task automatic do_access(
        input string       tag,
        input logic        lui, input logic mr, input logic mw,
        input logic [1:0]  ls,  input logic [1:0] ss, input logic zos,
        input logic [31:0] a,   input logic [31:0] wd, input logic [15:0] im,
        input int          ack_at, input logic [31:0] ack_data, input bit hold_start,
        input logic        x_we, input logic [3:0] x_be, input logic [31:0] x_addr,
        input logic [31:0] x_wdata,
        input int          x_req_cnt, input int x_done, input logic [31:0] x_rdata,
        input logic        x_merr, input logic x_terr);
        exp_t e;
        exp_t got;
        int   req_cnt;
        int   done_cyc;
        e.done_cyc = x_done;
        e.req_cnt  = x_req_cnt;
        e.rdata    = x_rdata;
        e.merr     = x_merr;
        e.terr     = x_terr;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; lui_or_other = lui; mem_read = mr; mem_write = mw;
        load_select = ls; store_signal = ss; zero_or_sign = zos;
        addr = a; wdata = wd; imm = im; dmem_ack = 1'b0;
        @(negedge clk);
        check({tag, "_busy_c0"}, {31'd0, busy}, 32'd0);
        req_cnt  = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
            @(posedge clk); #1;
            if (hold_start) begin
                addr = 32'h0000_0088; mem_write = 1'b1; wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            dmem_ack   = (cyc == ack_at);
            dmem_rdata = (cyc == ack_at) ? ack_data : 32'h5A5A_5A5A;
            @(negedge clk);
            if (dmem_req) begin
                req_cnt++;
                check({tag, "_we"},    {31'd0, dmem_we}, {31'd0, x_we});
                check({tag, "_be"},    {28'd0, dmem_be}, {28'd0, x_be});
                check({tag, "_addr"},  dmem_addr, x_addr);
                check({tag, "_wdata"}, dmem_wdata, x_wdata);
                check({tag, "_busy"},  {31'd0, busy}, 32'd1);
            end
            if (done) begin
                done_cyc = cyc;
                start    = 1'b0;
            end
        end
        dmem_ack = 1'b0;
        got = sb_q.pop_front();
        check({tag, "_done_cyc"}, done_cyc, got.done_cyc);
        check({tag, "_req_cnt"},  req_cnt,  got.req_cnt);
        check({tag, "_rdata"},    rdata,    got.rdata);
        check({tag, "_merr"},     {31'd0, misalign_err}, {31'd0, got.merr});
        check({tag, "_terr"},     {31'd0, timeout_err},  {31'd0, got.terr});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_once"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_req"},  {31'd0, dmem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        load_select = 2'b00; store_signal = 2'b00; zero_or_sign = 1'b0;
        lui_or_other = 1'b0; addr = 32'd0; wdata = 32'd0; imm = 16'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_req",   {31'd0, dmem_req}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_errs",  {30'd0, misalign_err, timeout_err}, 32'd0);
        check("rst_mem",   {27'd0, dmem_we, dmem_be}, 32'd0);

        // lb / lbu from the top byte lane
        do_access("lb_sx", 0,1,0, 2'b01,2'b00,1, 32'h1003, 0, 0, 1, 32'h80AA55CC, 0,
                  0, 4'hF, 32'h1000, 32'h0, 1, 2, 32'hFFFF_FF80, 0, 0);
        do_access("lb_zx", 0,1,0, 2'b01,2'b00,0, 32'h1003, 0, 0, 1, 32'h80AA55CC, 0,
                  0, 4'hF, 32'h1000, 32'h0, 1, 2, 32'h0000_0080, 0, 0);
        model_rdata = 32'h0000_0080;
        // sh with delayed ack; rdata untouched by a store
        do_access("sh", 0,0,1, 2'b00,2'b01,0, 32'h2002, 32'h1234BEEF, 0, 3, 32'h0, 0,
                  1, 4'hC, 32'h2000, 32'hBEEF_BEEF, 3, 4, model_rdata, 0, 0);
        // misaligned lw, then aligned lhu at the same address
        do_access("lw_mis", 0,1,0, 2'b00,2'b00,0, 32'h0006, 0, 0, 0, 32'h0, 0,
                  0, 4'hF, 32'h0, 32'h0, 0, 1, model_rdata, 1, 0);
        do_access("lhu", 0,1,0, 2'b10,2'b00,0, 32'h0006, 0, 0, 1, 32'hF00D_1234, 0,
                  0, 4'hF, 32'h0004, 32'h0, 1, 2, 32'h0000_F00D, 0, 0);
        // lui wins over mem_read
        do_access("lui", 1,1,0, 2'b11,2'b00,0, 32'h0, 0, 16'hABCD, 0, 32'h0, 0,
                  0, 4'hF, 32'h0, 32'h0, 0, 1, 32'hABCD_0000, 0, 0);
        model_rdata = 32'hABCD_0000;
        // timeout, then a clean access clears the flag; start held high through REQ
        do_access("lw_tmo", 0,1,0, 2'b00,2'b00,0, 32'h0040, 0, 0, 0, 32'h0, 0,
                  0, 4'hF, 32'h0040, 32'h0, TMO, TMO + 1, model_rdata, 0, 1);
        do_access("lw_hold", 0,1,0, 2'b00,2'b00,0, 32'h0044, 0, 0, 2, 32'h1357_9BDF, 1,
                  0, 4'hF, 32'h0044, 32'h0, 2, 3, 32'h1357_9BDF, 0, 0);
        // store word, misaligned store half
        do_access("sw", 0,0,1, 2'b00,2'b10,0, 32'h0010, 32'hCAFE_F00D, 0, 1, 32'h0, 0,
                  1, 4'hF, 32'h0010, 32'hCAFE_F00D, 1, 2, 32'h1357_9BDF, 0, 0);
        do_access("sh_mis", 0,0,1, 2'b00,2'b01,0, 32'h0011, 32'h1111, 0, 0, 32'h0, 0,
                  0, 4'hF, 32'h0, 32'h0, 0, 1, 32'h1357_9BDF, 1, 0);

        // start with no operation selected is ignored
        @(posedge clk); #1;
        start = 1'b1; lui_or_other = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nop_done", {30'd0, done, dmem_req}, 32'd0);
            check("nop_merr", {31'd0, misalign_err}, 32'd1);
        end

        // reset in the middle of a pending request, with start held during REQ
        @(posedge clk); #1;
        start = 1'b1; mem_read = 1'b1; load_select = 2'b00; addr = 32'h0300;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid_req_before", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 begin reset_n = 1'b1; start = 1'b0; end
        @(negedge clk);
        check("rstmid_req",   {31'd0, dmem_req}, 32'd0);
        check("rstmid_busy",  {31'd0, busy}, 32'd0);
        check("rstmid_rdata", rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_no_done", {30'd0, done, dmem_req}, 32'd0);
        end

        // every byte lane, both extensions, then byte stores to every lane
        for (int ln = 0; ln < 4; ln++) begin
            for (int sx = 0; sx < 2; sx++) begin
                do_access("lb_lane", 0,1,0, 2'b01,2'b00,sx[0], 32'h0500 + ln, 0, 0, 1,
                          32'h7F80_C301, 0, 0, 4'hF, 32'h0500, 32'h0, 1, 2,
                          model_lb(32'h7F80_C301, ln, sx[0]), 0, 0);
            end
        end
        model_rdata = model_lb(32'h7F80_C301, 3, 1'b1);
        for (int ln = 0; ln < 4; ln++) begin
            logic [7:0] bv;
            bv = 8'hA5 + 8'(ln);
            do_access("sb_lane", 0,0,1, 2'b00,2'b00,0, 32'h0600 + ln, {24'h123456, bv}, 0, 1,
                      32'h0, 0, 1, 4'(1 << ln), 32'h0600, 32'h0101_0101 * {24'd0, bv},
                      1, 2, model_rdata, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
